// File: rtl/reg_mem_multiport.sv
// rtl/reg_mem_multiport.sv - multi-channel regbus memory responder; optional REG_MEM_MULTIPORT_STATS_EN enables per-channel txn counters
module reg_mem_multiport #(
  parameter int unsigned          NumChannels = 4,
  parameter int unsigned          AddrWidth   = 48,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          Depth       = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int unsigned          Latency     = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumChannels-1:0]           req_valid_i,
  input  logic [NumChannels-1:0]           req_write_i,
  input  logic [NumChannels*AddrWidth-1:0] req_addr_i,
  input  logic [NumChannels*DataWidth-1:0] req_wdata_i,
  input  logic [NumChannels*DataWidth/8-1:0] req_wstrb_i,
  output logic [NumChannels-1:0]           rsp_ready_o,
  output logic [NumChannels*DataWidth-1:0] rsp_rdata_o,
  output logic [NumChannels-1:0]           rsp_error_o,
  output logic [NumChannels*32-1:0]        txn_cnt_o
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned Lsb   = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(Depth);
  localparam int unsigned PtrW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned CntW  = (Latency > 1) ? $clog2(Latency) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                 state_q;
  logic [PtrW-1:0]        rr_q;
  logic [PtrW-1:0]        gnt_q;
  logic                   wr_q;
  logic                   err_q;
  logic [IdxW-1:0]        idx_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [StrbW-1:0]       wstrb_q;
  logic [CntW-1:0]        lat_q;
  logic [DataWidth-1:0]   mem_q [Depth];

  logic                   arb_found;
  logic [PtrW-1:0]        arb_idx;
  logic [AddrWidth-1:0]   sel_addr;
  logic [AddrWidth-1:0]   sel_off;
  logic                   sel_err;
  logic [IdxW-1:0]        sel_idx;

  // Round-robin pick: first valid channel at or after the pointer, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (!arb_found && req_valid_i[(int'(rr_q) + i) % NumChannels]) begin
        arb_found = 1'b1;
        arb_idx   = PtrW'((int'(rr_q) + i) % NumChannels);
      end
    end
  end

  // Address decode of the winning request; errors cover underflow, misalignment and overrun
  always_comb begin
    sel_addr = req_addr_i[arb_idx*AddrWidth +: AddrWidth];
    sel_off  = sel_addr - BaseAddr;
    sel_err  = (sel_addr < BaseAddr) || (sel_off[Lsb-1:0] != '0) ||
               ((sel_off >> Lsb) >= AddrWidth'(Depth));
    sel_idx  = sel_off[Lsb +: IdxW];
  end

  // Transaction FSM: latch the granted request, count out the latency, respond for one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            gnt_q   <= arb_idx;
            wr_q    <= req_write_i[arb_idx];
            err_q   <= sel_err;
            idx_q   <= sel_idx;
            wdata_q <= req_wdata_i[arb_idx*DataWidth +: DataWidth];
            wstrb_q <= req_wstrb_i[arb_idx*StrbW +: StrbW];
            lat_q   <= CntW'(Latency - 1);
            state_q <= (Latency == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          lat_q <= lat_q - 1'b1;
          if (lat_q == CntW'(1)) state_q <= RESP;
        end
        RESP: begin
          rr_q    <= PtrW'((int'(gnt_q) + 1) % NumChannels);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit byte-strobed writes at the end of the response cycle; reset abandons the commit
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == RESP && wr_q && !err_q) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  // Response lanes: only the granted lane carries ready/rdata/error; reset suppresses the pulse
  always_comb begin
    rsp_ready_o = '0;
    rsp_rdata_o = '0;
    rsp_error_o = '0;
    if (state_q == RESP && !rst_i) begin
      rsp_ready_o[gnt_q] = 1'b1;
      rsp_error_o[gnt_q] = err_q;
      if (!wr_q && !err_q) rsp_rdata_o[gnt_q*DataWidth +: DataWidth] = mem_q[idx_q];
    end
  end

`ifdef REG_MEM_MULTIPORT_STATS_EN
  logic [NumChannels*32-1:0] txn_cnt_q;

  // Per-channel completion counters, wrapping at 32 bits, errors included
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_cnt_q <= '0;
    end else if (state_q == RESP) begin
      txn_cnt_q[gnt_q*32 +: 32] <= txn_cnt_q[gnt_q*32 +: 32] + 32'd1;
    end
  end

  assign txn_cnt_o = txn_cnt_q;
`else
  assign txn_cnt_o = '0;
`endif

  // A master must keep valid asserted from grant until its ready pulse
  valid_held_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                 (state_q != IDLE) |-> req_valid_i[gnt_q]);

endmodule

// File: tb/tb_reg_mem_multiport.sv
// tb/tb_reg_mem_multiport.sv - self-checking bench for reg_mem_multiport
module tb_reg_mem_multiport;
  localparam int N = 4, AW = 48, DW = 32, DEPTH = 1024, LAT = 3;
  localparam logic [47:0] BASE = 48'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*4-1:0]  req_wstrb;
  logic [N-1:0]    rsp_ready, rsp_error;
  logic [N*DW-1:0] rsp_rdata;
  logic [N*32-1:0] txn_cnt;

  reg_mem_multiport #(.NumChannels(N), .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH),
                      .BaseAddr(BASE), .Latency(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_ready_o(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .txn_cnt_o(txn_cnt));

  int checks = 0, errors = 0;

  // Reference model: word array, round-robin pointer
  logic [31:0] mm [DEPTH];
  int          m_rr = 0;
  int          exp_slot [N];

  // Group-run bookkeeping
  bit          g_wr [N];
  logic [47:0] g_addr [N];
  logic [31:0] g_wd [N], g_rd [N], g_exp_rd [N];
  logic [3:0]  g_ws [N];
  bit          g_er [N], g_exp_er [N], g_seen [N];
  int          g_off [N];
  int          g_multi, g_leak;

  function automatic bit m_err(input logic [47:0] a);
    if (a < BASE) return 1'b1;
    if (((a - BASE) % 4) != 0) return 1'b1;
    if (((a - BASE) / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_access(input bit wr, input logic [47:0] a,
                                           input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] w;
    int idx;
    if (m_err(a)) return 32'h0;
    idx = int'((a - BASE) / 4);
    if (!wr) return mm[idx];
    w = mm[idx];
    for (int b = 0; b < 4; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    mm[idx] = w;
    return 32'h0;
  endfunction

  // Grant order for a set of simultaneous requesters starting from pointer ptr
  function automatic void m_order(input logic [N-1:0] mask, input int ptr);
    logic [N-1:0] rem = mask;
    int p = ptr;
    for (int k = 0; k < N; k++) begin
      bit hit = 1'b0;
      for (int i = 0; i < N; i++) begin
        int c = (p + i) % N;
        if (!hit && rem[c]) begin
          exp_slot[c] = k; rem[c] = 1'b0; p = c + 1; hit = 1'b1;
        end
      end
    end
  endfunction

  task automatic do_txn(input int ch, input bit wr, input logic [47:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output bit er,
                        output int lat, output bit quiet);
    bit found = 1'b0;
    req_write[ch] = wr; req_addr[ch*AW +: AW] = addr;
    req_wdata[ch*DW +: DW] = wd; req_wstrb[ch*4 +: 4] = ws; req_valid[ch] = 1'b1;
    rd = 32'h0; er = 1'b0; lat = -1; quiet = 1'b1;
    for (int k = 1; k <= 50 && !found; k++) begin
      @(posedge clk); #1;
      if (rsp_ready[ch]) begin
        found = 1'b1; lat = k; rd = rsp_rdata[ch*DW +: DW]; er = rsp_error[ch];
        for (int c = 0; c < N; c++)
          if (c != ch && (rsp_ready[c] || rsp_error[c] || rsp_rdata[c*DW +: DW] != 0)) quiet = 1'b0;
      end
    end
    if (found) m_rr = (ch + 1) % N;
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  task automatic run_group(input logic [N-1:0] mask);
    logic [N-1:0] pend = mask, drop = '0;
    g_multi = 0; g_leak = 0;
    for (int c = 0; c < N; c++) begin
      g_seen[c] = 1'b0; g_off[c] = -1;
      if (mask[c]) begin
        req_write[c] = g_wr[c]; req_addr[c*AW +: AW] = g_addr[c];
        req_wdata[c*DW +: DW] = g_wd[c]; req_wstrb[c*4 +: 4] = g_ws[c]; req_valid[c] = 1'b1;
      end
    end
    for (int k = 1; k <= 200 && pend != '0; k++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~drop; drop = '0;
      if ($countones(rsp_ready) > 1) g_multi++;
      for (int c = 0; c < N; c++) begin
        if (!rsp_ready[c] && (rsp_error[c] || rsp_rdata[c*DW +: DW] != 0)) g_leak++;
        if (pend[c] && rsp_ready[c]) begin
          g_off[c] = k; g_rd[c] = rsp_rdata[c*DW +: DW]; g_er[c] = rsp_error[c];
          g_seen[c] = 1'b1; pend[c] = 1'b0; drop[c] = 1'b1; m_rr = (c + 1) % N;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = req_valid & ~(drop | pend);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      checks++; if (rsp_ready !== '0) begin errors++; $display("FAIL reset_ready: got %h expected 0", rsp_ready); end
      checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
      checks++; if (rsp_error !== '0) begin errors++; $display("FAIL reset_error: got %h expected 0", rsp_error); end
      checks++; if (txn_cnt !== '0) begin errors++; $display("FAIL reset_txn_cnt: got %h expected 0", txn_cnt); end
      rst = 1'b0; m_rr = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; bit er, q; int lat;
    void'(m_access(1'b1, BASE + 48'h10, 32'hDEADBEEF, 4'hF));
    do_txn(0, 1'b1, BASE + 48'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, q);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_wr_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rsp: got err=%0b rdata=%h expected err=0 rdata=0", er, rd); end
    do_txn(1, 1'b0, BASE + 48'h10, 32'h0, 4'h0, rd, er, lat, q);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_rd_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL basic_rd_data: got %h err=%0b expected deadbeef err=0", rd, er); end
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL basic_other_lanes: got quiet=%0b expected 1", q); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; bit er, q; int lat;
    void'(m_access(1'b1, BASE + 48'h40, 32'h11223344, 4'hF));
    do_txn(2, 1'b1, BASE + 48'h40, 32'h11223344, 4'hF, rd, er, lat, q);
    void'(m_access(1'b1, BASE + 48'h40, 32'hAABBCCDD, 4'h5));
    do_txn(1, 1'b1, BASE + 48'h40, 32'hAABBCCDD, 4'h5, rd, er, lat, q);
    do_txn(3, 1'b0, BASE + 48'h40, 32'h0, 4'h0, rd, er, lat, q);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_rr();
    for (int c = 0; c < N; c++) begin
      g_wr[c] = 1'b0; g_addr[c] = (c % 2) ? BASE + 48'h40 : BASE + 48'h10;
      g_wd[c] = '0; g_ws[c] = '0;
      g_exp_rd[c] = m_access(1'b0, g_addr[c], 32'h0, 4'h0);
    end
    m_order(4'hF, m_rr);
    run_group(4'hF);
    for (int c = 0; c < N; c++) begin
      checks++; if (g_off[c] !== LAT + exp_slot[c] * (LAT + 1)) begin errors++; $display("FAIL rr_timing ch%0d: got %0d expected %0d", c, g_off[c], LAT + exp_slot[c] * (LAT + 1)); end
      checks++; if (g_rd[c] !== g_exp_rd[c] || g_er[c] !== 1'b0) begin errors++; $display("FAIL rr_data ch%0d: got %h err=%0b expected %h err=0", c, g_rd[c], g_er[c], g_exp_rd[c]); end
    end
    checks++; if (g_multi !== 0) begin errors++; $display("FAIL rr_onehot: got %0d overlaps expected 0", g_multi); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; bit er, q; int lat;
    logic [47:0] bad [3];
    bad[0] = BASE + 48'(DEPTH * 4); bad[1] = BASE + 48'h2; bad[2] = BASE - 48'h4;
    for (int i = 0; i < 3; i++) begin
      do_txn(i, 1'b0, bad[i], 32'h0, 4'h0, rd, er, lat, q);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin errors++; $display("FAIL err_read%0d: got err=%0b rdata=%h lat=%0d expected err=1 rdata=0 lat=%0d", i, er, rd, lat, LAT); end
    end
    do_txn(3, 1'b1, BASE + 48'h12, 32'h0BADF00D, 4'hF, rd, er, lat, q);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_write: got err=%0b expected 1", er); end
    do_txn(0, 1'b0, BASE + 48'h10, 32'h0, 4'h0, rd, er, lat, q);
    checks++; if (rd !== m_access(1'b0, BASE + 48'h10, 32'h0, 4'h0)) begin errors++; $display("FAIL err_no_write: got %h expected %h", rd, m_access(1'b0, BASE + 48'h10, 32'h0, 4'h0)); end
  endtask

  task automatic test_fill();
    logic [31:0] rd, wd; bit er, q; int lat, bad = 0;
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      void'(m_access(1'b1, BASE + 48'(w * 4), wd, 4'hF));
      do_txn(int'($urandom_range(0, N - 1)), 1'b1, BASE + 48'(w * 4), wd, 4'hF, rd, er, lat, q);
      if (er !== 1'b0 || lat !== LAT) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_writes: got %0d bad responses expected 0", bad); end
  endtask

  task automatic test_random_seq();
    logic [31:0] rd, wd, exp; logic [47:0] a; logic [3:0] ws; bit er, q, wr, xer; int lat, ch;
    for (int i = 0; i < 30; i++) begin
      ch = int'($urandom_range(0, N - 1)); wr = 1'(($urandom) & 1); wd = $urandom; ws = 4'($urandom);
      case ($urandom_range(0, 5))
        0: a = BASE + 48'($urandom_range(0, 63) * 4) + 48'($urandom_range(1, 3));
        1: a = BASE + 48'(DEPTH * 4) + 48'($urandom_range(0, 15) * 4);
        default: a = BASE + 48'($urandom_range(0, 63) * 4);
      endcase
      xer = m_err(a);
      exp = m_access(wr, a, wd, ws);
      do_txn(ch, wr, a, wd, ws, rd, er, lat, q);
      checks++; if (rd !== exp || er !== xer || lat !== LAT || q !== 1'b1) begin errors++; $display("FAIL rand_seq%0d ch%0d: got rdata=%h err=%0b lat=%0d quiet=%0b expected rdata=%h err=%0b lat=%0d quiet=1", i, ch, rd, er, lat, q, exp, xer, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] mask;
    for (int it = 0; it < 10; it++) begin
      mask = N'($urandom_range(1, 15));
      for (int c = 0; c < N; c++) begin
        g_wr[c] = 1'(($urandom) & 1); g_wd[c] = $urandom; g_ws[c] = 4'($urandom);
        g_addr[c] = BASE + 48'((c * 16 + int'($urandom_range(0, 15))) * 4);
        if ($urandom_range(0, 5) == 0) g_addr[c] = g_addr[c] + 48'h1;
        if (mask[c]) begin
          g_exp_er[c] = m_err(g_addr[c]);
          g_exp_rd[c] = m_access(g_wr[c], g_addr[c], g_wd[c], g_ws[c]);
        end
      end
      m_order(mask, m_rr);
      run_group(mask);
      for (int c = 0; c < N; c++) begin
        if (mask[c]) begin
          checks++; if (g_off[c] !== LAT + exp_slot[c] * (LAT + 1) || g_rd[c] !== g_exp_rd[c] || g_er[c] !== g_exp_er[c]) begin errors++; $display("FAIL b2b%0d ch%0d: got off=%0d rdata=%h err=%0b expected off=%0d rdata=%h err=%0b", it, c, g_off[c], g_rd[c], g_er[c], LAT + exp_slot[c] * (LAT + 1), g_exp_rd[c], g_exp_er[c]); end
        end
      end
      checks++; if (g_multi !== 0 || g_leak !== 0) begin errors++; $display("FAIL b2b%0d_lanes: got overlaps=%0d leaks=%0d expected 0 0", it, g_multi, g_leak); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit er, q; int lat, seen = 0;
    void'(m_access(1'b1, BASE + 48'h20, 32'hCAFE0123, 4'hF));
    do_txn(1, 1'b1, BASE + 48'h20, 32'hCAFE0123, 4'hF, rd, er, lat, q);
    req_write[0] = 1'b1; req_addr[0 +: AW] = BASE + 48'h20; req_wdata[0 +: DW] = 32'h55;
    req_wstrb[0 +: 4] = 4'hF; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    if (rsp_ready != '0) seen++;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (rsp_ready != '0) seen++; end
    req_valid[0] = 1'b0; rst = 1'b0; m_rr = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_ready != '0) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", seen); end
    do_txn(2, 1'b0, BASE + 48'h20, 32'h0, 4'h0, rd, er, lat, q);
    checks++; if (rd !== 32'hCAFE0123 || er !== 1'b0) begin errors++; $display("FAIL rstmid_no_commit: got %h err=%0b expected cafe0123 err=0", rd, er); end
  endtask

  task automatic test_stats();
    logic [31:0] rd; bit er, q; int lat;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_rr = 0;
    for (int i = 0; i < 5; i++)
      do_txn(2, 1'b0, (i == 3) ? BASE + 48'h1 : BASE + 48'(i * 4), 32'h0, 4'h0, rd, er, lat, q);
`ifdef REG_MEM_MULTIPORT_STATS_EN
    checks++; if (txn_cnt !== {32'd0, 32'd5, 32'd0, 32'd0}) begin errors++; $display("FAIL stats_count: got %h expected 00000000_00000005_00000000_00000000", txn_cnt); end
    force dut.txn_cnt_q = {N{32'hFFFFFFFF}};
    @(posedge clk); #1;
    release dut.txn_cnt_q;
    do_txn(2, 1'b0, BASE, 32'h0, 4'h0, rd, er, lat, q);
    checks++; if (txn_cnt !== {32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin errors++; $display("FAIL stats_wrap: got %h expected ffffffff_00000000_ffffffff_ffffffff", txn_cnt); end
`else
    checks++; if (txn_cnt !== '0) begin errors++; $display("FAIL stats_disabled: got %h expected 0", txn_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobe();
    test_rr();
    test_errors();
    test_fill();
    test_random_seq();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
